// File: rtl/freelist_ctrl_pkg.sv
// Shared parameters, preg range macro and FSM encoding for the rename free list.
// Optional checker macro used by freelist_ctrl: FREELIST_CHECK_EN.
`ifndef FREELIST_CTRL_PKG_SV
`define FREELIST_CTRL_PKG_SV

// Preg number range: $clog2(NUM_PREG)-1 : 0 with NUM_PREG = 64.
`define PREG_RANGE 5:0

package freelist_ctrl_pkg;
  localparam int NUM_PREG = 64;
  localparam int NUM_LREG = 32;
  localparam int FL_DEPTH = NUM_PREG - NUM_LREG;
  localparam int PREG_W   = $clog2(NUM_PREG);
  localparam int FL_IDX_W = $clog2(FL_DEPTH);
  localparam int FL_PTR_W = FL_IDX_W + 1;

  typedef enum logic {
    FL_NORMAL  = 1'b0,
    FL_RECOVER = 1'b1
  } fl_state_e;
endpackage

`endif

// File: rtl/fl_ptr_inc.sv
// Circular-buffer pointer increment by 0/1/2; the MSB is the wrap bit and
// toggles naturally because FL_DEPTH is a power of two.
module fl_ptr_inc
  import freelist_ctrl_pkg::*;
(
  input  logic [FL_PTR_W-1:0] i_ptr,
  input  logic [1:0]          i_inc,
  output logic [FL_PTR_W-1:0] o_ptr
);
  assign o_ptr = i_ptr + {{(FL_PTR_W-2){1'b0}}, i_inc};
endmodule

// File: rtl/freelist_ctrl.sv
// Free physical-register pool for the 2-wide rename stage, with committed head
// for one-cycle flush recovery. Optional checker: define FREELIST_CHECK_EN.
module freelist_ctrl
  import freelist_ctrl_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                rn2fl_instr0_lrd_valid,
  input  logic                rn2fl_instr1_lrd_valid,
  output logic [`PREG_RANGE]  fl2rn_instr0prd,
  output logic [`PREG_RANGE]  fl2rn_instr1prd,
  output logic                fl2rn_ready,
  output logic [FL_PTR_W-1:0] fl2rn_avail_cnt,
  input  logic                rob2fl_commit0_valid,
  input  logic [`PREG_RANGE]  rob2fl_commit0_old_prd,
  input  logic                rob2fl_commit1_valid,
  input  logic [`PREG_RANGE]  rob2fl_commit1_old_prd,
  input  logic                flush_valid,
  output logic                fl_err,
  output logic                dbg_state
);
  // Handshake: rename may consume pregs only in a cycle where fl2rn_ready=1 and
  // flush_valid=0; requests in any other cycle are dropped. Frees are always accepted.
  logic [PREG_W-1:0]   r_mem [FL_DEPTH];
  logic [FL_PTR_W-1:0] r_head, r_tail, r_arch_head;
  fl_state_e           r_state, w_state_nxt;

  logic [1:0]          w_alloc_n, w_free_n, w_head_inc, w_rd1_off;
  logic [FL_PTR_W-1:0] w_head_nxt, w_tail_nxt, w_tail1, w_arch_nxt, w_rd1_ptr, w_count;
  logic                w_alloc_fire;

  assign w_alloc_n    = {1'b0, rn2fl_instr0_lrd_valid} + {1'b0, rn2fl_instr1_lrd_valid};
  assign w_free_n     = {1'b0, rob2fl_commit0_valid} + {1'b0, rob2fl_commit1_valid};
  assign w_count      = r_tail - r_head;
  assign fl2rn_ready  = (w_count >= FL_PTR_W'(2)) && (r_state == FL_NORMAL);
  assign w_alloc_fire = fl2rn_ready && !flush_valid;
  assign w_head_inc   = w_alloc_fire ? w_alloc_n : 2'd0;
  // instr1 takes the head entry only when it is the sole consumer; otherwise it
  // previews the next entry so the idle pair shows two distinct pregs.
  assign w_rd1_off    = {1'b0, rn2fl_instr0_lrd_valid | ~rn2fl_instr1_lrd_valid};

  fl_ptr_inc u_head_inc  (.i_ptr(r_head),      .i_inc(w_head_inc),                   .o_ptr(w_head_nxt));
  fl_ptr_inc u_rd1_inc   (.i_ptr(r_head),      .i_inc(w_rd1_off),                    .o_ptr(w_rd1_ptr));
  fl_ptr_inc u_tail_inc  (.i_ptr(r_tail),      .i_inc(w_free_n),                     .o_ptr(w_tail_nxt));
  fl_ptr_inc u_tail1_inc (.i_ptr(r_tail),      .i_inc({1'b0, rob2fl_commit0_valid}), .o_ptr(w_tail1));
  fl_ptr_inc u_arch_inc  (.i_ptr(r_arch_head), .i_inc(w_free_n),                     .o_ptr(w_arch_nxt));

  assign fl2rn_instr0prd = r_mem[r_head[FL_IDX_W-1:0]];
  assign fl2rn_instr1prd = r_mem[w_rd1_ptr[FL_IDX_W-1:0]];
  assign fl2rn_avail_cnt = w_count;
  assign dbg_state       = r_state;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FL_NORMAL:  if (flush_valid) w_state_nxt = FL_RECOVER;
      FL_RECOVER: w_state_nxt = flush_valid ? FL_RECOVER : FL_NORMAL;
      default:    w_state_nxt = FL_NORMAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_DEPTH; i++) r_mem[i] <= PREG_W'(NUM_LREG + i);
      r_head      <= '0;
      r_arch_head <= '0;
      r_tail      <= FL_PTR_W'(FL_DEPTH);
      r_state     <= FL_NORMAL;
    end else begin
      r_state     <= w_state_nxt;
      // Flush rewinds to the committed head, counting commits of this same cycle.
      r_head      <= flush_valid ? w_arch_nxt : w_head_nxt;
      r_tail      <= w_tail_nxt;
      r_arch_head <= w_arch_nxt;
      if (rob2fl_commit0_valid) r_mem[r_tail[FL_IDX_W-1:0]] <= rob2fl_commit0_old_prd;
      if (rob2fl_commit1_valid) r_mem[w_tail1[FL_IDX_W-1:0]] <= rob2fl_commit1_old_prd;
    end
  end

`ifdef FREELIST_CHECK_EN
  logic                r_err;
  logic                w_err_evt;
  logic [FL_PTR_W-1:0] w_spec_cnt;

  assign w_spec_cnt = r_head - r_arch_head;
  assign w_err_evt  = ((rob2fl_commit0_valid | rob2fl_commit1_valid) && (w_count == FL_PTR_W'(FL_DEPTH)))
                    || (rob2fl_commit1_valid && !rob2fl_commit0_valid)
                    || ((rn2fl_instr0_lrd_valid | rn2fl_instr1_lrd_valid) && !fl2rn_ready && !flush_valid)
                    || ({{(FL_PTR_W-2){1'b0}}, w_free_n} > w_spec_cnt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= r_err | w_err_evt;
  end
  assign fl_err = r_err;
`else
  assign fl_err = 1'b0;
`endif
endmodule
